// File: rtl/ps_serializer_hs_pkg.sv
// Shared definitions for the PHY serial transmit/receive path: default symbol
// width, line-idle fill word, K28.5 comma codes and shift-register operations.
package ps_defs;

    localparam int unsigned DEF_WIDTH = 10;
    localparam logic [DEF_WIDTH-1:0] DEF_IDLE_WORD = '1;

    // K28.5 comma, negative and positive running disparity
    localparam logic [9:0] K28_5_NEG = 10'h17C;
    localparam logic [9:0] K28_5_POS = 10'h283;

    typedef enum logic [1:0] {
        SR_HOLD,
        SR_SHIFT,
        SR_LOAD
    } sr_op_e;

endpackage

// File: rtl/ps_serializer_hs_shift_reg.sv
// Output shift register for the serializer: parallel load, one-place shift toward
// the output end, and the current output bit selected by bit order.
module ps_shift_reg
    import ps_defs::*;
#(
    parameter int unsigned         WIDTH      = DEF_WIDTH,
    parameter bit                  LSB_FIRST  = 1'b1,
    parameter logic [WIDTH-1:0]    RESET_WORD = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  sr_op_e           op,
    input  logic [WIDTH-1:0] load_word,
    output logic             out_bit
);

    logic [WIDTH-1:0] shreg;

    // Vacated positions are filled with ones; they never reach the output
    // before the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= RESET_WORD;
        end else begin
            case (op)
                SR_LOAD:  shreg <= load_word;
                SR_SHIFT: begin
                    if (LSB_FIRST) begin
                        shreg <= {1'b1, shreg[WIDTH-1:1]};
                    end else begin
                        shreg <= {shreg[WIDTH-2:0], 1'b1};
                    end
                end
                default:  shreg <= shreg;
            endcase
        end
    end

    always_comb begin
        out_bit = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
    end

endmodule

// File: rtl/ps_serializer_hs.sv
// Parallel-to-serial converter with valid/ready handshake, one-word holding
// buffer, selectable bit order and idle-word fill between data words.
module ps_serializer_hs
    import ps_defs::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter bit               LSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] IDLE_WORD = '1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic             OS,
    output logic             SOW,
    output logic             BUSY
);

    localparam int unsigned      CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             data_flag;
    logic             boundary;
    logic             accept;
    sr_op_e           sr_op;
    logic [WIDTH-1:0] load_word;

    always_comb begin
        boundary  = (cnt == LAST);
        D_READY   = !hold_full && !RESET;
        accept    = D_VALID && D_READY;
        sr_op     = SR_SHIFT;
        load_word = IDLE_WORD;
        if (boundary) begin
            sr_op = SR_LOAD;
            if (hold_full) begin
                load_word = hold;
            end
        end
        SOW  = (cnt == '0);
        BUSY = data_flag;
    end

    // Accept requires an empty buffer and drain requires a full one, so the two
    // hold_full updates below never apply in the same cycle.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            data_flag <= 1'b0;
        end else begin
            if (boundary) begin
                cnt <= '0;
                if (hold_full) begin
                    data_flag <= 1'b1;
                    hold_full <= 1'b0;
                end else begin
                    data_flag <= 1'b0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                hold      <= D;
                hold_full <= 1'b1;
            end
        end
    end

    ps_shift_reg #(
        .WIDTH      (WIDTH),
        .LSB_FIRST  (LSB_FIRST),
        .RESET_WORD (IDLE_WORD)
    ) u_shift (
        .clk       (CLOCK),
        .rst       (RESET),
        .op        (sr_op),
        .load_word (load_word),
        .out_bit   (OS)
    );

endmodule

// File: tb/tb_ps_serializer_hs.sv
// Directed bench for ps_serializer_hs: table of per-cycle vectors for the default
// 10-bit LSB-first instance plus hand sequences for mid-word reset and 8-bit MSB-first.
module tb_ps_serializer_hs;
    import ps_defs::*;

    typedef struct {
        string      tag;
        logic       rst;
        logic       dv;
        logic [9:0] d;
        logic       os;
        logic       sow;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       dv;
    logic [9:0] d;
    logic       os, sow, busy, rdy;
    logic       dv8;
    logic [7:0] d8;
    logic       os8, sow8, busy8, rdy8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps_serializer_hs u_dut (
        .CLOCK   (clk),
        .RESET   (rst),
        .D       (d),
        .D_VALID (dv),
        .D_READY (rdy),
        .OS      (os),
        .SOW     (sow),
        .BUSY    (busy)
    );

    ps_serializer_hs #(
        .WIDTH     (8),
        .LSB_FIRST (1'b0)
    ) u_dut8 (
        .CLOCK   (clk),
        .RESET   (rst),
        .D       (d8),
        .D_VALID (dv8),
        .D_READY (rdy8),
        .OS      (os8),
        .SOW     (sow8),
        .BUSY    (busy8)
    );

    task automatic chk(input string name, input int cyc, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Inputs are already driven; check the main instance mid-cycle, then advance.
    task automatic tick(input string tag, input int cyc,
                        input logic eos, input logic esow, input logic ebusy, input logic erdy);
        @(negedge clk);
        chk({tag, ".os"},   cyc, os,   eos);
        chk({tag, ".sow"},  cyc, sow,  esow);
        chk({tag, ".busy"}, cyc, busy, ebusy);
        chk({tag, ".rdy"},  cyc, rdy,  erdy);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input string tag, input logic r, input logic v, input logic [9:0] dd,
                                input logic eos, input logic esow, input logic ebusy, input logic erdy);
        vec_t x;
        x.tag = tag; x.rst = r; x.dv = v; x.d = dd;
        x.os = eos; x.sow = esow; x.busy = ebusy; x.rdy = erdy;
        vecs.push_back(x);
    endfunction

    function automatic void add_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) add(tag, 1'b0, 1'b0, 10'h000, 1'b1, (i % 10) == 0, 1'b0, 1'b1);
    endfunction

    initial begin
        logic [9:0] w;
        logic [7:0] exp8 [8];
        exp8 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // 1: reset held 3 cycles, then 30 idle cycles
        for (int i = 0; i < 3; i++) add("rst", 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0);
        add_idle("idle", 30);

        // 2: single K28.5- word accepted at cycle 0
        add("single", 1'b0, 1'b1, K28_5_NEG, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 10; i++) add("single", 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        w = K28_5_NEG;
        for (int i = 0; i < 10; i++) add("single", 1'b0, 1'b0, 10'h000, w[i], i == 0, 1'b1, 1'b1);
        add_idle("single_idle", 10);

        // 3: back-to-back K28.5- then K28.5+, D_VALID held
        add("b2b", 1'b0, 1'b1, K28_5_NEG, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 10; i++) add("b2b", 1'b0, 1'b1, K28_5_POS, 1'b1, 1'b0, 1'b0, 1'b0);
        w = K28_5_NEG;
        for (int i = 0; i < 10; i++) add("b2b", 1'b0, i == 0, K28_5_POS, w[i], i == 0, 1'b1, i == 0);
        w = K28_5_POS;
        for (int i = 0; i < 10; i++) add("b2b", 1'b0, 1'b0, 10'h000, w[i], i == 0, 1'b1, 1'b1);
        add_idle("b2b_idle", 10);

        // 4: backpressure, D changes every cycle while the buffer is full
        add("bp", 1'b0, 1'b1, 10'h155, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 10; i++) add("bp", 1'b0, 1'b1, 10'(i * 93), 1'b1, 1'b0, 1'b0, 1'b0);
        w = 10'h155;
        for (int i = 0; i < 10; i++) add("bp", 1'b0, 1'b0, 10'h000, w[i], i == 0, 1'b1, 1'b1);
        add_idle("bp_idle", 10);

        rst = 1'b1; dv = 1'b0; d = '0; dv8 = 1'b0; d8 = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; dv = vecs[i].dv; d = vecs[i].d;
            tick(vecs[i].tag, i, vecs[i].os, vecs[i].sow, vecs[i].busy, vecs[i].rdy);
        end

        // 5: reset at bit 4 of a data word with another word held
        rst = 1'b0; dv = 1'b1; d = 10'h000;
        tick("mid_rst", 0, 1'b1, 1'b1, 1'b0, 1'b1);
        dv = 1'b0;
        for (int c = 1; c < 10; c++) tick("mid_rst", c, 1'b1, 1'b0, 1'b0, 1'b0);
        dv = 1'b1; d = 10'h2AA;
        tick("mid_rst", 10, 1'b0, 1'b1, 1'b1, 1'b1);
        dv = 1'b0;
        for (int c = 11; c < 14; c++) tick("mid_rst", c, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick("mid_rst", 14, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) tick("post_rst", c, 1'b1, (c % 10) == 0, 1'b0, 1'b1);

        // 6: WIDTH=8, MSB first, 8'hA5
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 18; c++) begin
            dv8 = (c == 0);
            d8  = 8'hA5;
            @(negedge clk);
            chk("w8.sow",  c, sow8,  (c % 8) == 0);
            chk("w8.os",   c, os8,   (c >= 8 && c < 16) ? exp8[c - 8][0] : 1'b1);
            chk("w8.busy", c, busy8, c >= 8 && c < 16);
            chk("w8.rdy",  c, rdy8,  c == 0 || c >= 8);
            @(posedge clk);
            #1;
        end
        dv8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
